// File: rtl/q2_mem_responder_pkg.sv
// Shared Q2 memory types: responder FSM states, default bus widths, read latency limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package q2_pkg;

    localparam int Q2_ADDR_W    = 12;
    localparam int Q2_DATA_W    = 12;
    localparam int READ_LAT_MAX = 4;
    localparam int LAT_CNT_W    = $clog2(READ_LAT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_ACK,
        ST_WR_ACK,
        ST_DEP,
        ST_RELEASE
    } q2_mem_state_t;

endpackage

// File: rtl/q2_mem_responder_if.sv
// Q2 address/data bus as seen by the memory responder; split in/out with output enable.
// Latency: n/a (wires only).
// Backpressure: four-phase rd_req/wr_req level requests closed by a one-cycle ack.
interface q2_mem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] abus_in;
    logic [DATA_W-1:0] dbus_in;
    logic [DATA_W-1:0] dbus_out;
    logic              dbus_oe;
    logic              rd_req;
    logic              wr_req;
    logic              ack;
    logic              busy;

    modport master (
        output abus_in, dbus_in, rd_req, wr_req,
        input  dbus_out, dbus_oe, ack, busy
    );

    modport slave (
        input  abus_in, dbus_in, rd_req, wr_req,
        output dbus_out, dbus_oe, ack, busy
    );
endinterface

// File: rtl/q2_mem_responder_array.sv
// Single-port synchronous RAM, one write enable, registered read; contents never reset.
// Latency: read data valid one cycle after re; write lands on the clock edge with we.
// Backpressure: none, accepts one access per cycle.
module q2_mem_array #(
    parameter int ADDR_W = 12,
    parameter int W      = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/q2_mem_responder.sv
// Q2 memory responder: CPU read/write over req/ack plus front-panel deposit; Q2_MEM_PARITY_EN adds parity.
// Latency: write ack 1 cycle after accept, read ack READ_LAT+1 cycles after accept (READ_LAT 1..4).
// Backpressure: requests held until ack; RELEASE waits for both requests low before re-arming.
module q2_mem_responder
    import q2_pkg::*;
#(
    parameter int ADDR_W   = Q2_ADDR_W,
    parameter int DATA_W   = Q2_DATA_W,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    q2_mem_responder_if.slave bus,
    input  logic              panel_dep,
    input  logic [DATA_W-1:0] panel_sw,
    output logic              par_err
);

`ifdef Q2_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(READ_LAT - 1);

    q2_mem_state_t         state, state_nxt;
    logic [LAT_CNT_W-1:0]  lat_cnt, lat_cnt_nxt;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  ld_cpu, ld_dep;
    logic                  mem_we, mem_re;
    logic [MEM_W-1:0]      mem_wdata, mem_rdata;
    logic [1:0]            dep_sync;
    logic                  dep_d, dep_edge, dep_pend;

    // Panel button is asynchronous: two-flop sync, then rising-edge detect into a sticky pending flag.
    assign dep_edge = dep_sync[1] & ~dep_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dep_sync <= '0;
            dep_d    <= 1'b0;
            dep_pend <= 1'b0;
        end else begin
            dep_sync <= {dep_sync[0], panel_dep};
            dep_d    <= dep_sync[1];
            dep_pend <= (dep_pend & ~ld_dep) | dep_edge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            if (ld_cpu || ld_dep) begin
                addr_q <= bus.abus_in;
                data_q <= ld_dep ? panel_sw : bus.dbus_in;
            end
        end
    end

    // Write wins over read when both are raised; a deposit only goes when the CPU is quiet.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        ld_cpu      = 1'b0;
        ld_dep      = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.wr_req) begin
                    state_nxt = ST_WR_ACK;
                    ld_cpu    = 1'b1;
                end else if (bus.rd_req) begin
                    state_nxt   = ST_RD_WAIT;
                    ld_cpu      = 1'b1;
                    lat_cnt_nxt = LAT_LOAD;
                end else if (dep_pend) begin
                    state_nxt = ST_DEP;
                    ld_dep    = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                mem_re = 1'b1;
                if (lat_cnt == '0) begin
                    state_nxt = ST_RD_ACK;
                end else begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end
            end
            ST_RD_ACK: state_nxt = ST_RELEASE;
            ST_WR_ACK: begin
                mem_we    = 1'b1;
                state_nxt = ST_RELEASE;
            end
            ST_DEP: begin
                mem_we    = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_RELEASE: begin
                if (!bus.rd_req && !bus.wr_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef Q2_MEM_PARITY_EN
    assign mem_wdata = {^data_q, data_q};

    // Stored even parity makes the XOR over the whole word zero when intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (state == ST_RD_ACK && (^mem_rdata)) begin
            par_err <= 1'b1;
        end
    end
`else
    assign mem_wdata = data_q;
    assign par_err   = 1'b0;
`endif

    q2_mem_array #(
        .ADDR_W (ADDR_W),
        .W      (MEM_W)
    ) u_array (
        .clk   (clk),
        .addr  (addr_q),
        .we    (mem_we),
        .wdata (mem_wdata),
        .re    (mem_re),
        .rdata (mem_rdata)
    );

    assign bus.dbus_oe  = (state == ST_RD_ACK);
    assign bus.dbus_out = bus.dbus_oe ? mem_rdata[DATA_W-1:0] : '0;
    assign bus.ack      = (state == ST_RD_ACK) || (state == ST_WR_ACK);
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_q2_mem_responder.sv
// Scoreboard bench for q2_mem_responder: directed CPU reads/writes, held requests, deposits, reset abort.
module tb_q2_mem_responder;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int RL = 2;

    typedef struct {
        bit             is_rd;
        logic [DW-1:0]  data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          panel_dep;
    logic [DW-1:0] panel_sw;
    logic          par_err;

    int   tests;
    int   fails;
    int   ack_cnt;
    exp_t exp_q[$];

    q2_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    q2_mem_responder #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .READ_LAT (RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .panel_dep (panel_dep),
        .panel_sw  (panel_sw),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every ack pops one expectation; read acks must drive the expected word.
    always @(negedge clk) begin
        if (rst_n && bus.ack) begin
            exp_t e;
            ack_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack_dbus_oe", {31'd0, bus.dbus_oe}, {31'd0, e.is_rd});
                if (e.is_rd) begin
                    check("read_data", {20'd0, bus.dbus_out}, {20'd0, e.data});
                end
            end
        end
        if (rst_n && bus.dbus_oe) begin
            check("oe_without_ack", {31'd0, bus.ack}, 32'd1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 50);
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue one request from idle, check ack latency from the raise, then drop it.
    task automatic cpu_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
        exp_t e;
        int   lat = 0;
        wait_idle();
        @(posedge clk);
        #1;
        bus.abus_in = a;
        bus.dbus_in = d;
        bus.rd_req  = rd;
        bus.wr_req  = wr;
        e.is_rd = rd && !wr;
        e.data  = exp_d;
        exp_q.push_back(e);
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.ack && lat < 20);
        check(wr ? "write_ack_latency" : "read_ack_latency", lat, wr ? 1 : RL + 1);
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] va [4];
        logic [DW-1:0] vd [4];
        int            acks0;
        tests = 0; fails = 0; ack_cnt = 0;
        rst_n = 1'b0;
        panel_dep = 1'b0;
        panel_sw  = 12'h777;
        bus.abus_in = '0;
        bus.dbus_in = '0;
        bus.rd_req  = 1'b0;
        bus.wr_req  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {31'd0, bus.ack}, 32'd0);
        check("reset_oe", {31'd0, bus.dbus_oe}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_dbus_out", {20'd0, bus.dbus_out}, 32'd0);
        check("reset_par_err", {31'd0, par_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cpu_op(1'b0, 1'b1, 12'h0A5, 12'h3C3, 12'h000);
        cpu_op(1'b1, 1'b0, 12'h0A5, 12'h000, 12'h3C3);

        va = '{12'h000, 12'h7FF, 12'h123, 12'hABC};
        vd = '{12'hFFF, 12'h800, 12'h5A5, 12'h0F0};
        for (int i = 0; i < 4; i++) cpu_op(1'b0, 1'b1, va[i], vd[i], 12'h000);
        for (int i = 3; i >= 0; i--) cpu_op(1'b1, 1'b0, va[i], 12'h000, vd[i]);

        // Held read: one ack over ten cycles, block stays in RELEASE until the request drops.
        begin
            exp_t e;
            wait_idle();
            acks0 = ack_cnt;
            @(posedge clk);
            #1;
            bus.abus_in = 12'h0A5;
            bus.rd_req  = 1'b1;
            e.is_rd = 1'b1;
            e.data  = 12'h3C3;
            exp_q.push_back(e);
            repeat (10) @(posedge clk);
            @(negedge clk);
            check("held_ack_count", ack_cnt - acks0, 32'd1);
            check("held_busy", {31'd0, bus.busy}, 32'd1);
            @(posedge clk);
            #1 bus.rd_req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("held_release_idle", {31'd0, bus.busy}, 32'd0);
        end

        cpu_op(1'b1, 1'b1, 12'hFFF, 12'h001, 12'h000);
        cpu_op(1'b1, 1'b0, 12'hFFF, 12'h000, 12'h001);

        // Reset in the middle of a read wait aborts it; no ack may follow.
        wait_idle();
        @(posedge clk);
        #1;
        bus.abus_in = 12'h0A5;
        bus.rd_req  = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("abort_ack", {31'd0, bus.ack}, 32'd0);
        check("abort_oe", {31'd0, bus.dbus_oe}, 32'd0);
        check("abort_busy_next", {31'd0, bus.busy}, 32'd0);
        bus.rd_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle_after", {31'd0, bus.busy}, 32'd0);
        cpu_op(1'b1, 1'b0, 12'h0A5, 12'h000, 12'h3C3);

        // Deposit edge during a CPU write is serviced afterwards at the then-current address.
        acks0 = ack_cnt;
        fork
            cpu_op(1'b0, 1'b1, 12'h010, 12'h555, 12'h000);
            begin
                @(negedge clk);
                @(posedge clk);
                #1 panel_dep = 1'b1;
                repeat (2) @(posedge clk);
                #1 panel_dep = 1'b0;
            end
        join
        bus.abus_in = 12'h020;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("deposit_no_ack", ack_cnt - acks0, 32'd1);
        cpu_op(1'b1, 1'b0, 12'h020, 12'h000, 12'h777);
        cpu_op(1'b1, 1'b0, 12'h010, 12'h000, 12'h555);

`ifdef Q2_MEM_PARITY_EN
        cpu_op(1'b0, 1'b1, 12'h005, 12'h0AB, 12'h000);
        cpu_op(1'b1, 1'b0, 12'h005, 12'h000, 12'h0AB);
        check("parity_clean", {31'd0, par_err}, 32'd0);
        wait_idle();
        dut.u_array.mem[5][0] = ~dut.u_array.mem[5][0];
        cpu_op(1'b1, 1'b0, 12'h005, 12'h000, 12'h0AA);
        check("parity_flag", {31'd0, par_err}, 32'd1);
        cpu_op(1'b1, 1'b0, 12'h0A5, 12'h000, 12'h3C3);
        check("parity_sticky", {31'd0, par_err}, 32'd1);
`else
        check("par_err_tied", {31'd0, par_err}, 32'd0);
`endif

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
